// File: rtl/if_id_stage.sv
// if_id_stage: MIPS32 fetch front end with req/ready imem handshake and IF/ID register.
// Optional IF_ID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IR,
  output logic [31:0]      pc_plus4_ID,
  output logic             valid_ID
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_skid_instr, r_skid_pc4, w_pc4;
  logic        r_skid_vld, w_done;
  assign imem_addr = r_pc;
  assign w_pc4     = r_pc + 32'd4;
  always_comb begin
    imem_req    = rst_n && ((r_state != FETCH) || (!hazard_detected && !r_skid_vld));
    w_done      = imem_req && imem_ready && (r_state != DISCARD);
    // an unanswered request in WAIT/DISCARD must be drained after a redirect
    w_state_nxt = branch_taken ? ((r_state != FETCH && !imem_ready) ? DISCARD : FETCH)
                : (r_state == FETCH) ? ((imem_req && !imem_ready) ? WAIT : FETCH)
                : (imem_ready ? FETCH : r_state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_skid_vld   <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= 32'd0;
      IR           <= NOP_INSTR;
      pc_plus4_ID  <= 32'd0;
      valid_ID     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (branch_taken) begin
        r_pc       <= {branch_target[31:2], 2'b00};
        IR         <= NOP_INSTR;
        valid_ID   <= 1'b0;
        r_skid_vld <= 1'b0;
      end else if (hazard_detected) begin
        if (w_done) begin
          r_skid_vld   <= 1'b1;
          r_skid_instr <= imem_rdata;
          r_skid_pc4   <= w_pc4;
          r_pc         <= w_pc4;
        end
      end else if (r_skid_vld) begin
        IR          <= r_skid_instr;
        pc_plus4_ID <= r_skid_pc4;
        valid_ID    <= 1'b1;
        r_skid_vld  <= 1'b0;
      end else if (w_done) begin
        IR          <= imem_rdata;
        pc_plus4_ID <= w_pc4;
        valid_ID    <= 1'b1;
        r_pc        <= w_pc4;
      end else begin
        IR       <= NOP_INSTR;
        valid_ID <= 1'b0;
      end
    end
  end
`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard_detected && !branch_taken && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed bench with an IF/ID scoreboard for if_id_stage.
module tb_if_id_stage;
  typedef struct {logic [31:0] ir; logic [31:0] pc4;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        hazard_detected = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_req, valid_ID;
  logic [31:0] imem_addr, imem_rdata, IR, pc_plus4_ID;
  logic        ov_en = 1'b0;
  logic [31:0] ov_data = 32'd0;
`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  exp_t        q[$];
  exp_t        e;
  logic [31:0] e_ir = 32'd0, e_pc4 = 32'd0;
  logic        e_v = 1'b0;
  int          n_chk = 0, n_fail = 0;

  // memory returns its address as data unless a specific stale word is injected
  assign imem_rdata = ov_en ? ov_data : imem_addr;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .IR(IR), .pc_plus4_ID(pc_plus4_ID),
    .valid_ID(valid_ID)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic b, input logic [31:0] t, input logic r);
    hazard_detected = h;
    branch_taken    = b;
    branch_target   = t;
    imem_ready      = r;
    #1;
  endtask

  task automatic push(input logic [31:0] ir, input logic [31:0] pc4);
    exp_t x;
    x.ir  = ir;
    x.pc4 = pc4;
    q.push_back(x);
  endtask

  task automatic tick(input logic exp_v);
    logic stall;
    stall = hazard_detected && !branch_taken;
    @(posedge clk);
    #1;
    if (stall) begin
      chk("hold_ir", IR, e_ir);
      chk("hold_pc4", pc_plus4_ID, e_pc4);
      chk("hold_valid", {31'd0, valid_ID}, {31'd0, e_v});
    end else if (exp_v) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL scoreboard_empty observed=%h expected=none", IR);
      end else begin
        e     = q.pop_front();
        e_ir  = e.ir;
        e_pc4 = e.pc4;
        e_v   = 1'b1;
        chk("ir", IR, e_ir);
        chk("pc4", pc_plus4_ID, e_pc4);
        chk("valid", {31'd0, valid_ID}, 32'd1);
      end
    end else begin
      e_ir = 32'd0;
      e_v  = 1'b0;
      chk("bubble_ir", IR, 32'd0);
      chk("bubble_valid", {31'd0, valid_ID}, 32'd0);
    end
  endtask

  initial begin
    #2;
    chk("rst_ir", IR, 32'd0);
    chk("rst_valid", {31'd0, valid_ID}, 32'd0);
    chk("rst_pc4", pc_plus4_ID, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    #10;
    rst_n = 1'b1;
    // zero-wait streaming
    drive(0, 0, 0, 1);
    chk("req_on", {31'd0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'd0);
    push(32'h0, 32'h4); tick(1);
    push(32'h4, 32'h8); tick(1);
    push(32'h8, 32'hC); tick(1);
    // two-cycle stall
    drive(1, 0, 0, 1);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    tick(0); tick(0);
    chk("stall_pc", imem_addr, 32'hC);
    drive(0, 0, 0, 1);
    push(32'hC, 32'h10); tick(1);
    // redirect with misaligned target
    drive(0, 1, 32'h0000_0103, 1);
    tick(0);
    chk("br_addr", imem_addr, 32'h100);
    drive(0, 0, 0, 1);
    push(32'h100, 32'h104); tick(1);
    // redirect while waiting: stale response must be dropped
    drive(0, 0, 0, 0); tick(0);
    drive(0, 1, 32'h200, 0); tick(0);
    chk("disc_addr", imem_addr, 32'h200);
    drive(0, 0, 0, 0);
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    tick(0);
    ov_en   = 1'b1;
    ov_data = 32'hDEAD_0104;
    drive(0, 0, 0, 1); tick(0);
    ov_en = 1'b0;
    drive(0, 0, 0, 1);
    push(32'h200, 32'h204); tick(1);
    // skid buffer capture under stall
    drive(0, 1, 32'h24, 1); tick(0);
    drive(0, 0, 0, 0); tick(0);
    drive(1, 0, 0, 1); tick(0);
    chk("skid_pc", imem_addr, 32'h28);
    drive(1, 0, 0, 1);
    chk("skid_full_req", {31'd0, imem_req}, 32'd0);
    tick(0);
    drive(0, 0, 0, 1);
    chk("skid_drain_req", {31'd0, imem_req}, 32'd0);
    push(32'h24, 32'h28); tick(1);
    push(32'h28, 32'h2C); tick(1);
    // PC wrap
    drive(0, 1, 32'hFFFF_FFFC, 1); tick(0);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1);
    push(32'hFFFF_FFFC, 32'h0); tick(1);
    chk("wrap_addr", imem_addr, 32'h0);
    // asynchronous reset mid-WAIT
    drive(0, 0, 0, 0); tick(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ir", IR, 32'd0);
    chk("arst_valid", {31'd0, valid_ID}, 32'd0);
    chk("arst_pc4", pc_plus4_ID, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    e_ir  = 32'd0;
    e_pc4 = 32'd0;
    e_v   = 1'b0;
    drive(0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk("arst_hold_ir", IR, 32'd0);
    chk("arst_hold_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    push(32'h0, 32'h4); tick(1);
    push(32'h4, 32'h8); tick(1);
    chk("sb_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch front end plus the IF/ID pipeline register of the 5-stage MIPS32 pipeline.
- Owns the PC and issues requests to instruction memory with a req/ready handshake.
- Presents the fetched instruction as IR to decode and to the load-use/branch hazard unit.
- Consumes that unit's hazard_detected (stall) and the branch-taken redirect (flush).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, encoding inserted into IR as a bubble (sll $0,$0,0).
CNT_W, 16, width of the performance counters (only used with the optional feature).

Ports:
clk  input  1  pipeline clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
hazard_detected  input  1  stall request from the hazard unit; freeze PC and IF/ID.
branch_taken  input  1  redirect; flush IF/ID and load branch_target into PC.
branch_target  input  32  redirect address; bits [1:0] are ignored (forced to 0).
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address (equals PC).
imem_ready  input  1  response valid; imem_rdata is sampled in the same cycle.
imem_rdata  input  32  fetched instruction word.
IR  output  32  IF/ID instruction register.
pc_plus4_ID  output  32  IF/ID copy of fetch PC + 4.
valid_ID  output  1  1 = IR holds a real instruction; 0 = bubble.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - PC = RESET_PC, IR = NOP_INSTR, pc_plus4_ID = 0, valid_ID = 0.
  - imem_req = 0, skid buffer empty, state = FETCH.
  - Outputs stay at these values while rst_n is low.
- Reset released mid-operation: any outstanding memory response is dropped; the block restarts cleanly from RESET_PC.
- imem_addr = PC at all times. imem_req is registered-free combinational from state and the inputs.
- States:
  - FETCH:
    - imem_req = 1 unless hazard_detected = 1 or the skid buffer is full.
    - If req and ready in the same cycle → 1-cycle fetch.
    - If req and not ready → WAIT.
  - WAIT: imem_req = 1 (held); stay until imem_ready = 1, then return to FETCH.
  - DISCARD: imem_req = 1; entered on a redirect while a request is outstanding. On imem_ready the response is dropped and the state returns to FETCH. No new address is issued until then.
- Per-cycle priority: branch_taken > hazard_detected > fetch completion.
- branch_taken = 1:
  - PC ← {branch_target[31:2], 2'b00}.
  - IR ← NOP_INSTR, valid_ID ← 0, skid buffer cleared.
  - Next state: DISCARD if currently WAIT with no response this cycle; otherwise FETCH.
  - A fetch that completes in the same cycle is dropped.
  - Applies even if hazard_detected = 1.
- hazard_detected = 1 (no branch):
  - PC, IR, pc_plus4_ID and valid_ID hold.
  - A response arriving in WAIT is stored in the 1-entry skid buffer (instr, pc+4) and PC advances by 4.
  - When the stall releases, IF/ID loads from the skid buffer first, then the buffer empties.
- Fetch completion (no stall, no branch): IR ← imem_rdata, pc_plus4_ID ← PC + 4, valid_ID ← 1, PC ← PC + 4.
- No stall, no completion (waiting on memory): IR ← NOP_INSTR, valid_ID ← 0 (bubble inserted).
- Arithmetic: PC + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No exception is raised.
- Throughput: one instruction per cycle with a zero-wait memory.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt [CNT_W-1:0] and flush_cnt [CNT_W-1:0].
  - stall_cnt increments every cycle hazard_detected = 1 and branch_taken = 0.
  - flush_cnt increments every cycle branch_taken = 1.
  - Both saturate at all-ones and reset to 0 asynchronously.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then zero-wait memory returning addr as data → IR = 0x0, 0x4, 0x8 on consecutive cycles; valid_ID = 1 from cycle 2; pc_plus4_ID = IR + 4.
- hazard_detected high 2 cycles while IR = 0x8 → IR, PC and valid_ID frozen; imem_req = 0; IR = 0xC on the cycle after release.
- branch_taken with branch_target = 0x0000_0103 → next IR = NOP_INSTR, valid_ID = 0; imem_addr = 0x100; then IR = 0x100.
- imem_ready held low 3 cycles, branch at cycle 2 → DISCARD entered; the late response is dropped; the next fetch is the target and the stale instruction never appears in IR.
- Stall asserted while WAIT response arrives (data 0x24) → skid buffer captures it; after release IR = 0x24 with pc_plus4_ID = 0x28, and no fetch is lost or duplicated.
- PC preset to 0xFFFF_FFFC via branch → following fetch address 0x0000_0000; rst_n pulsed low mid-WAIT → outputs return to reset values immediately.
